// File: rtl/uart_prog_loader_pkg.sv
// Shared constants and state encodings for the UART program loader and its byte receiver.
package uart_prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_LEN,
        GET_DATA,
        GET_SUM,
        DONE
    } load_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, start-bit glitch rejection, centre sampling.
module uart_rx_byte
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int HALF  = CLKS_PER_BIT / 2;

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // The synchronizer and edge detect already cost two cycles of the start bit,
    // so the half-bit count starts at 2 to keep samples close to bit centres.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RX_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        state    <= RX_START;
                        baud_cnt <= CNT_W'(2);
                    end
                end
                RX_START: begin
                    if (baud_cnt >= CNT_W'(HALF - 1)) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        baud_cnt <= '0;
                        shift    <= {rx_sync, shift[7:1]};
                        bit_cnt  <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (baud_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                        baud_cnt <= '0;
                        state    <= RX_IDLE;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shift;
                        end else begin
                            rx_ferr  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial boot loader: receives a framed, checksummed program image over UART and
// writes it into instruction memory, holding the CPU until a load completes cleanly.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int BAUD           = 115200,
    parameter int IMEM_WORDS     = 64,
    parameter int TIMEOUT_CYCLES = (CLK_HZ / BAUD) * 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        usb_rx,
    output logic        cpu_hold,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        load_done,
    output logic        load_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int WORD_W       = $clog2(IMEM_WORDS + 1);
    localparam int IDLE_W       = $clog2(TIMEOUT_CYCLES + 1);

    logic              rx_valid;
    logic              rx_ferr;
    logic [7:0]        rx_data;
    load_state_t       state;
    logic [WORD_W-1:0] len;
    logic [WORD_W-1:0] word_idx;
    logic [1:0]        byte_idx;
    logic [7:0]        sum;
    logic [23:0]       word_reg;
    logic [IDLE_W-1:0] idle_cnt;
    logic              in_frame;
    logic              timeout;
    logic              abort_now;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .rx      (usb_rx),
        .rx_valid(rx_valid),
        .rx_data (rx_data),
        .rx_ferr (rx_ferr)
    );

    assign in_frame = (state == GET_LEN) || (state == GET_DATA) || (state == GET_SUM);
    // A byte arriving in the timeout cycle wins over the timeout.
    assign timeout  = in_frame && !rx_valid && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        abort_now = 1'b0;
        if (in_frame && (rx_ferr || timeout)) begin
            abort_now = 1'b1;
        end
        if (state == GET_LEN && rx_valid && (rx_data == 8'd0 || int'(rx_data) > IMEM_WORDS)) begin
            abort_now = 1'b1;
        end
        if (state == GET_SUM && rx_valid && rx_data != sum) begin
            abort_now = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= WAIT_SYNC;
            len        <= '0;
            word_idx   <= '0;
            byte_idx   <= '0;
            sum        <= '0;
            word_reg   <= '0;
            idle_cnt   <= '0;
            cpu_hold   <= 1'b1;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (!in_frame || rx_valid) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end

            // Words already written stay in memory; only the flags record the failure.
            if (abort_now) begin
                load_err <= 1'b1;
                cpu_hold <= 1'b1;
                state    <= WAIT_SYNC;
            end else begin
                case (state)
                    WAIT_SYNC, DONE: begin
                        if (rx_valid && rx_data == SYNC_BYTE) begin
                            state     <= GET_LEN;
                            cpu_hold  <= 1'b1;
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                        end
                    end
                    GET_LEN: begin
                        if (rx_valid) begin
                            len      <= WORD_W'(rx_data);
                            word_idx <= '0;
                            byte_idx <= '0;
                            sum      <= '0;
                            state    <= GET_DATA;
                        end
                    end
                    GET_DATA: begin
                        if (rx_valid) begin
                            word_reg <= {rx_data, word_reg[23:8]};
                            sum      <= sum + rx_data;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= 32'(word_idx) << 2;
                                imem_wdata <= {rx_data, word_reg};
                                word_idx   <= word_idx + WORD_W'(1);
                                if (word_idx == len - WORD_W'(1)) begin
                                    state <= GET_SUM;
                                end
                            end
                        end
                    end
                    GET_SUM: begin
                        if (rx_valid) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                            cpu_hold  <= 1'b0;
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed self-checking bench for uart_prog_loader at 10 clocks per UART bit.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CLK_HZ         = 1000;
    localparam int BAUD           = 100;
    localparam int IMEM_WORDS     = 64;
    localparam int TIMEOUT_CYCLES = 400;
    localparam int CPB            = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        usb_rx;
    logic        cpu_hold;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        load_done;
    logic        load_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rxv_cyc = 0;
    int rxv_count = 0;
    logic [7:0] last_rx = 8'h00;
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];

    logic [7:0] frame_ok     [11] = '{8'hA5, 8'h02, 8'h33, 8'h05, 8'hA5, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h41};
    logic [7:0] frame_badsum [11] = '{8'hA5, 8'h02, 8'h33, 8'h05, 8'hA5, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h42};
    logic [7:0] frame_long   [11] = '{8'hA5, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] frame_one    [11] = '{8'hA5, 8'h01, 8'h13, 8'h01, 8'h50, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    uart_prog_loader #(
        .CLK_HZ        (CLK_HZ),
        .BAUD          (BAUD),
        .IMEM_WORDS    (IMEM_WORDS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .usb_rx    (usb_rx),
        .cpu_hold  (cpu_hold),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (imem_we) begin
            we_addr.push_back(imem_addr);
            we_data.push_back(imem_wdata);
        end
        if (dut.u_rx.rx_valid) begin
            rxv_count++;
            rxv_cyc = cyc;
            last_rx = dut.u_rx.rx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        @(posedge clk);
        #1 usb_rx = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 usb_rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 usb_rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 usb_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] bytes [11], input int n, input int bad_idx);
        for (int i = 0; i < n; i++) begin
            applyStimulus(bytes[i], (i == bad_idx) ? 1'b0 : 1'b1);
            if (i == bad_idx) repeat (2 * CPB) @(posedge clk);
        end
    endtask

    task automatic settle();
        repeat (5) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n;
        reset  = 1'b1;
        usb_rx = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("rst_imem_addr", imem_addr, 32'd0);
        checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
        checkOutput("rst_load_done", 32'(load_done), 32'd0);
        checkOutput("rst_load_err", 32'(load_err), 32'd0);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);

        $display("[TB] single byte and glitch");
        rxv_count = 0;
        applyStimulus(8'h55, 1'b1);
        settle();
        lat = rxv_cyc - start_cyc;
        checkOutput("rx_pulse_count", 32'(rxv_count), 32'd1);
        checkOutput("rx_data_55", 32'(last_rx), 32'h55);
        checkOutput("rx_latency_in_window", 32'(lat >= 93 && lat <= 97), 32'd1);
        rxv_count = 0;
        @(posedge clk);
        #1 usb_rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 usb_rx = 1'b1;
        repeat (40) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch_no_valid", 32'(rxv_count), 32'd0);

        $display("[TB] good two-word frame");
        we_addr.delete();
        we_data.delete();
        send_frame(frame_ok, 10, -1);
        settle();
        checkOutput("f2_hold_before_sum", 32'(cpu_hold), 32'd1);
        applyStimulus(frame_ok[10], 1'b1);
        settle();
        checkOutput("f2_we_count", 32'(we_addr.size()), 32'd2);
        checkOutput("f2_addr0", we_addr[0], 32'd0);
        checkOutput("f2_data0", we_data[0], 32'h00A50533);
        checkOutput("f2_addr1", we_addr[1], 32'd4);
        checkOutput("f2_data1", we_data[1], 32'h00500113);
        checkOutput("f2_load_done", 32'(load_done), 32'd1);
        checkOutput("f2_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("f2_load_err", 32'(load_err), 32'd0);

        $display("[TB] bad checksum frame");
        we_addr.delete();
        we_data.delete();
        send_frame(frame_badsum, 11, -1);
        settle();
        checkOutput("bs_we_count", 32'(we_addr.size()), 32'd2);
        checkOutput("bs_load_err", 32'(load_err), 32'd1);
        checkOutput("bs_load_done", 32'(load_done), 32'd0);
        checkOutput("bs_cpu_hold", 32'(cpu_hold), 32'd1);

        $display("[TB] oversize length then one-word frame");
        we_addr.delete();
        we_data.delete();
        send_frame(frame_long, 2, -1);
        settle();
        checkOutput("len65_load_err", 32'(load_err), 32'd1);
        checkOutput("len65_no_we", 32'(we_addr.size()), 32'd0);
        send_frame(frame_one, 7, -1);
        settle();
        checkOutput("one_load_done", 32'(load_done), 32'd1);
        checkOutput("one_load_err", 32'(load_err), 32'd0);
        checkOutput("one_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("one_we_count", 32'(we_addr.size()), 32'd1);
        checkOutput("one_data0", we_data[0], 32'h00500113);

        $display("[TB] framing error and timeout");
        we_addr.delete();
        we_data.delete();
        send_frame(frame_ok, 11, 4);
        settle();
        checkOutput("ferr_load_err", 32'(load_err), 32'd1);
        checkOutput("ferr_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("ferr_state", 32'(dut.state), 32'(WAIT_SYNC));
        checkOutput("ferr_no_we", 32'(we_addr.size()), 32'd0);
        send_frame(frame_ok, 2, -1);
        repeat (350) @(posedge clk);
        @(negedge clk);
        checkOutput("to_not_yet", 32'(load_err), 32'd0);
        repeat (60) @(posedge clk);
        @(negedge clk);
        checkOutput("to_load_err", 32'(load_err), 32'd1);
        checkOutput("to_state", 32'(dut.state), 32'(WAIT_SYNC));

        $display("[TB] reset mid-frame then reload");
        send_frame(frame_ok, 7, -1);
        #1 reset = 1'b1;
        #1;
        checkOutput("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        checkOutput("mid_rst_imem_we", 32'(imem_we), 32'd0);
        checkOutput("mid_rst_imem_addr", imem_addr, 32'd0);
        checkOutput("mid_rst_imem_wdata", imem_wdata, 32'd0);
        checkOutput("mid_rst_load_done", 32'(load_done), 32'd0);
        checkOutput("mid_rst_load_err", 32'(load_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        we_addr.delete();
        we_data.delete();
        send_frame(frame_ok, 11, -1);
        settle();
        checkOutput("re_load_done", 32'(load_done), 32'd1);
        checkOutput("re_cpu_hold", 32'(cpu_hold), 32'd0);
        checkOutput("re_we_count", 32'(we_addr.size()), 32'd2);
        checkOutput("re_data1", we_data[1], 32'h00500113);

        n = 0;
        fork
            applyStimulus(SYNC_BYTE, 1'b1);
            begin
                @(negedge clk);
                while (!dut.u_rx.rx_valid && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                checkOutput("sync_valid_seen", 32'(n < 300), 32'd1);
                @(negedge clk);
                checkOutput("sync_cpu_hold_1clk", 32'(cpu_hold), 32'd1);
                checkOutput("sync_load_done_clr", 32'(load_done), 32'd0);
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
